// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg
//   Shared definitions for the SPI command sequencer: command byte values,
//   the sequencer state type and a helper that maps a command byte to the
//   state that handles its payload.
package spi_cmd_pkg;

  localparam logic [7:0] CMD_CONF_WR = 8'h2A;
  localparam logic [7:0] CMD_DATA_WR = 8'h2C;
  localparam logic [7:0] CMD_REFRESH = 8'h2D;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONF_H = 3'd1,
    CONF_L = 3'd2,
    DATA   = 3'd3,
    DROP   = 3'd4
  } state_t;

  // Refresh and unknown commands carry no meaningful payload, so both
  // park in DROP until the frame ends.
  function automatic state_t cmd_next_state(input logic [7:0] cmd);
    state_t nxt;
    case (cmd)
      CMD_CONF_WR: nxt = CONF_H;
      CMD_DATA_WR: nxt = DATA;
      default:     nxt = DROP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl
//   Splits each SPI chip-select frame into a command byte and its payload,
//   and turns the payload into frame RAM writes, an LED byte-count config
//   update or a refresh request towards the waveform engine.
//
// Ports
//   clk_in           system clock
//   rst_in           asynchronous reset, active high
//   spi_cs_n_in      chip select (synchronous), high = frame boundary
//   byte_rdy_in      one-cycle strobe qualifying byte_data_in
//   byte_data_in     received byte
//   ram_wr_en_out    frame RAM write enable, one cycle per payload byte
//   ram_wr_addr_out  frame RAM write address
//   ram_wr_data_out  frame RAM write data
//   cfg_cnt_out      LED byte count for the waveform engine
//   refresh_req_out  refresh request level, held until acknowledged
//   refresh_ack_in   one-cycle acceptance of the refresh request
//   ovf_err_out      sticky frame RAM overflow flag
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for the command byte of a new frame
// CONF_H | CMD_CONF_WR seen, waiting for the count high byte
// CONF_L | high byte held, waiting for the count low byte
// DATA   | CMD_DATA_WR seen, every byte goes to the frame RAM
// DROP   | nothing more to do in this frame, ignore bytes until CS high
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  spi_cs_n_in,
  input  logic                  byte_rdy_in,
  input  logic [7:0]            byte_data_in,
  output logic                  ram_wr_en_out,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_out,
  output logic [7:0]            ram_wr_data_out,
  output logic [CNT_WIDTH-1:0]  cfg_cnt_out,
  output logic                  refresh_req_out,
  input  logic                  refresh_ack_in,
  output logic                  ovf_err_out
);

  state_t state_q, state_d;

  // One bit wider than the address: the MSB marks that the last RAM
  // address has already been written, which blocks further writes
  // instead of letting the pointer wrap.
  logic [ADDR_WIDTH:0] wr_ptr_q;
  logic [7:0]          cfg_hi_q;
  logic [15:0]         cfg_word;

  logic ptr_clr;
  logic wr_fire;
  logic ovf_hit;
  logic hi_load;
  logic cfg_load;
  logic refresh_set;

  assign cfg_word = {cfg_hi_q, byte_data_in};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A strobe coinciding with CS high belongs to no frame and is dropped.
  always_comb begin
    state_d     = state_q;
    ptr_clr     = 1'b0;
    wr_fire     = 1'b0;
    ovf_hit     = 1'b0;
    hi_load     = 1'b0;
    cfg_load    = 1'b0;
    refresh_set = 1'b0;
    if (spi_cs_n_in) begin
      state_d = IDLE;
    end else if (byte_rdy_in) begin
      case (state_q)
        IDLE: begin
          state_d     = cmd_next_state(byte_data_in);
          ptr_clr     = (byte_data_in == CMD_DATA_WR);
          refresh_set = (byte_data_in == CMD_REFRESH);
        end
        CONF_H: begin
          hi_load = 1'b1;
          state_d = CONF_L;
        end
        CONF_L: begin
          cfg_load = 1'b1;
          state_d  = DROP;
        end
        DATA: begin
          if (wr_ptr_q[ADDR_WIDTH]) begin
            ovf_hit = 1'b1;
          end else begin
            wr_fire = 1'b1;
          end
        end
        DROP: begin
          state_d = DROP;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ram_wr_en_out   <= 1'b0;
      ram_wr_addr_out <= '0;
      ram_wr_data_out <= 8'h00;
      wr_ptr_q        <= '0;
      ovf_err_out     <= 1'b0;
    end else begin
      ram_wr_en_out <= wr_fire;
      if (wr_fire) begin
        ram_wr_addr_out <= wr_ptr_q[ADDR_WIDTH-1:0];
        ram_wr_data_out <= byte_data_in;
      end
      if (ptr_clr) begin
        wr_ptr_q <= '0;
      end else if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
      if (ptr_clr) begin
        ovf_err_out <= 1'b0;
      end else if (ovf_hit) begin
        ovf_err_out <= 1'b1;
      end
    end
  end

  // The count register only moves once both payload bytes have arrived,
  // so a frame cut short in CONF_H/CONF_L leaves it untouched.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cfg_hi_q    <= 8'h00;
      cfg_cnt_out <= '0;
    end else begin
      if (hi_load) begin
        cfg_hi_q <= byte_data_in;
      end
      if (cfg_load) begin
        cfg_cnt_out <= CNT_WIDTH'(cfg_word);
      end
    end
  end

  // A new request wins over a simultaneous ack of the previous one.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      refresh_req_out <= 1'b0;
    end else if (refresh_set) begin
      refresh_req_out <= 1'b1;
    end else if (refresh_ack_in) begin
      refresh_req_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
module tb_spi_cmd_ctrl;
  localparam int AW    = 2;
  localparam int CW    = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          spi_cs_n_in;
  logic          byte_rdy_in;
  logic [7:0]    byte_data_in;
  logic          ram_wr_en_out;
  logic [AW-1:0] ram_wr_addr_out;
  logic [7:0]    ram_wr_data_out;
  logic [CW-1:0] cfg_cnt_out;
  logic          refresh_req_out;
  logic          refresh_ack_in;
  logic          ovf_err_out;

  spi_cmd_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .spi_cs_n_in     (spi_cs_n_in),
    .byte_rdy_in     (byte_rdy_in),
    .byte_data_in    (byte_data_in),
    .ram_wr_en_out   (ram_wr_en_out),
    .ram_wr_addr_out (ram_wr_addr_out),
    .ram_wr_data_out (ram_wr_data_out),
    .cfg_cnt_out     (cfg_cnt_out),
    .refresh_req_out (refresh_req_out),
    .refresh_ack_in  (refresh_ack_in),
    .ovf_err_out     (ovf_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;
  typedef logic [7:0] bq_t[$];

  int errors = 0;
  int checks = 0;

  // Reference model: frame-level bookkeeping of what the spec says happens.
  wr_t        exp_q[$];
  int         m_pos;
  logic [7:0] m_cmd;
  logic [7:0] m_hi;
  int         m_ptr;
  int         m_cfg;
  bit         m_ovf;
  bit         m_req;
  wr_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pos = 0; m_cmd = 8'h00; m_hi = 8'h00; m_ptr = 0;
    m_cfg = 0; m_ovf = 0; m_req = 0;
  endtask

  task automatic model_apply(input bit cs, input bit rdy, input logic [7:0] d, input bit ack);
    bit set_req;
    set_req = 0;
    if (cs) begin
      m_pos = 0;
    end else if (rdy) begin
      if (m_pos == 0) begin
        m_cmd = d;
        if (d == 8'h2C) begin m_ptr = 0; m_ovf = 0; end
        if (d == 8'h2D) set_req = 1;
      end else if (m_cmd == 8'h2A) begin
        if (m_pos == 1) m_hi = d;
        else if (m_pos == 2) m_cfg = (m_hi * 256 + d) % (1 << CW);
      end else if (m_cmd == 8'h2C) begin
        if (m_ptr < DEPTH) begin
          exp_q.push_back('{a: AW'(m_ptr), d: d});
          m_ptr++;
        end else begin
          m_ovf = 1;
        end
      end
      m_pos++;
    end
    if (set_req) m_req = 1;
    else if (ack) m_req = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the model
  // updated to what the DUT must show after that edge.
  task automatic step(input bit cs, input bit rdy, input logic [7:0] d, input bit ack);
    spi_cs_n_in    = cs;
    byte_rdy_in    = rdy;
    byte_data_in   = d;
    refresh_ack_in = ack;
    @(posedge clk_in);
    model_apply(cs, rdy, d, ack);
    #1;
  endtask

  task automatic frame(input bq_t b, input bit close_rdy);
    step(0, 0, 8'h00, 0);
    foreach (b[i]) begin
      step(0, 1, b[i], 0);
      step(0, 0, 8'h00, 0);
    end
    step(1, close_rdy, 8'h2C, 0);
    step(1, 0, 8'h00, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"},   ram_wr_en_out, 0);
    chk({tag, "_wr_addr"}, ram_wr_addr_out, 0);
    chk({tag, "_wr_data"}, ram_wr_data_out, 0);
    chk({tag, "_cfg"},     cfg_cnt_out, 0);
    chk({tag, "_req"},     refresh_req_out, 0);
    chk({tag, "_ovf"},     ovf_err_out, 0);
  endtask

  // Monitor: pops an expected write whenever the DUT writes, and flags
  // any expected write that did not show up in its cycle.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (ram_wr_en_out) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%02h, expected no write", ram_wr_addr_out, ram_wr_data_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(ram_wr_addr_out), 32'(mon_e.a));
          chk("wr_data", 32'(ram_wr_data_out), 32'(mon_e.d));
        end
      end else if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_write: got no write, expected addr=%0d data=%02h", mon_e.a, mon_e.d);
      end
      chk("cfg_cnt", 32'(cfg_cnt_out), 32'(m_cfg));
      chk("ovf_err", 32'(ovf_err_out), 32'(m_ovf));
      chk("refresh_req", 32'(refresh_req_out), 32'(m_req));
    end
  end

  initial begin
    bq_t bq;
    rst_in = 1'b1; spi_cs_n_in = 1'b1; byte_rdy_in = 1'b0;
    byte_data_in = 8'h00; refresh_ack_in = 1'b0;
    model_reset();
    #2;
    chk_reset_vals("por");
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    step(1, 0, 8'h00, 0);

    // Basic data frame
    bq = '{8'h2C, 8'h11, 8'h22, 8'h33};
    frame(bq, 0);
    chk("ovf_after_3", ovf_err_out, 0);

    // Reset in the middle of a DATA frame
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h2C, 0);
    step(0, 1, 8'h44, 0);
    step(0, 1, 8'h55, 0);
    step(0, 1, 8'h66, 0);
    rst_in = 1'b1;
    model_reset();
    #1;
    chk_reset_vals("midrst");
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    step(1, 0, 8'h00, 0);
    bq = '{8'h2C, 8'h77};
    frame(bq, 0);

    // Config writes, including a truncated one
    bq = '{8'h2A, 8'h01, 8'h2C};
    frame(bq, 0);
    chk("cfg_12C", cfg_cnt_out, 12'h12C);
    bq = '{8'h2A, 8'h05};
    frame(bq, 0);
    chk("cfg_keep", cfg_cnt_out, 12'h12C);

    // Overflow and its clear
    bq = '{8'h2C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    frame(bq, 0);
    chk("ovf_set", ovf_err_out, 1);
    bq = '{8'h2C};
    frame(bq, 0);
    chk("ovf_clr", ovf_err_out, 0);

    // Refresh handshake
    bq = '{8'h2D};
    frame(bq, 0);
    frame(bq, 0);
    chk("req_pending", refresh_req_out, 1);
    step(1, 0, 8'h00, 1);
    chk("req_acked", refresh_req_out, 0);
    frame(bq, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h2D, 1);
    chk("req_new_wins", refresh_req_out, 1);
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 1);
    chk("req_cleared", refresh_req_out, 0);

    // Unknown command, stray strobe on CS rise
    bq = '{8'h55, 8'h2C, 8'hAA};
    frame(bq, 1);
    chk("unk_cfg", cfg_cnt_out, 12'h12C);
    chk("unk_req", refresh_req_out, 0);

    // Random frames
    for (int f = 0; f < 200; f++) begin
      int sel, len;
      bq.delete();
      sel = $urandom_range(0, 3);
      case (sel)
        0: bq.push_back(8'h2A);
        1: bq.push_back(8'h2C);
        2: bq.push_back(8'h2D);
        default: bq.push_back(8'($urandom_range(0, 255)));
      endcase
      len = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) bq.push_back(8'($urandom_range(0, 255)));
      step(0, 0, 8'h00, $urandom_range(0, 7) == 0);
      foreach (bq[i]) begin
        step(0, 1, bq[i], $urandom_range(0, 7) == 0);
        repeat ($urandom_range(0, 2)) step(0, 0, 8'h00, $urandom_range(0, 7) == 0);
      end
      step(1, $urandom_range(0, 1), 8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
      step(1, 0, 8'h00, $urandom_range(0, 3) == 0);
    end

    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
